// File: rtl/syscall_unit.sv
// Syscall service engine: console print-int / print-char, exit and
// bad-code trapping, with a valid/ready byte stream to the console sink.
module syscall_unit #(
  parameter int unsigned NEWLINE_AFTER_INT = 0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        Syscall_IN,
  input  logic [31:0] V0_IN,
  input  logic [31:0] A0_IN,
  input  logic        CHAR_READY,
  output logic [7:0]  CHAR_OUT,
  output logic        CHAR_VALID,
  output logic        DONE_OUT,
  output logic        BUSY_OUT,
  output logic        HALT_OUT,
  output logic        ERROR_OUT
);

  typedef enum logic [2:0] {
    IDLE, DECODE, SIGN, DIGIT, EMIT, NL, DONE, HALTED
  } state_t;

  state_t      state_q;
  logic        sys_prev_q;
  logic [31:0] code_q;
  logic [31:0] arg_q;
  logic [31:0] mag_q;
  logic [3:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        lead_q;
  logic [7:0]  char_q;
  logic        valid_q;
  logic        done_q;
  logic        busy_q;
  logic        halt_q;
  logic        err_q;
  logic [31:0] pow_val;

  always_comb begin
    pow_val = 32'd1;
    case (idx_q)
      4'd9:    pow_val = 32'd1000000000;
      4'd8:    pow_val = 32'd100000000;
      4'd7:    pow_val = 32'd10000000;
      4'd6:    pow_val = 32'd1000000;
      4'd5:    pow_val = 32'd100000;
      4'd4:    pow_val = 32'd10000;
      4'd3:    pow_val = 32'd1000;
      4'd2:    pow_val = 32'd100;
      4'd1:    pow_val = 32'd10;
      default: pow_val = 32'd1;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      sys_prev_q <= 1'b0;
      code_q     <= '0;
      arg_q      <= '0;
      mag_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      lead_q     <= 1'b0;
      char_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sys_prev_q <= Syscall_IN;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Syscall_IN && !sys_prev_q) begin
            code_q  <= V0_IN;
            arg_q   <= A0_IN;
            busy_q  <= 1'b1;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (code_q == 32'd1) begin
            mag_q   <= arg_q[31] ? (~arg_q + 32'd1) : arg_q;
            char_q  <= 8'h2D;
            valid_q <= arg_q[31];
            state_q <= SIGN;
          end else if (code_q == 32'd11) begin
            char_q  <= arg_q[7:0];
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else if (code_q == 32'd10) begin
            halt_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        SIGN: begin
          // Non-negative values pass straight through with valid never raised
          if (!valid_q || CHAR_READY) begin
            valid_q <= 1'b0;
            idx_q   <= 4'd9;
            cnt_q   <= '0;
            lead_q  <= 1'b1;
            state_q <= DIGIT;
          end
        end
        DIGIT: begin
          if (mag_q >= pow_val) begin
            mag_q <= mag_q - pow_val;
            cnt_q <= cnt_q + 4'd1;
          end else if (cnt_q != 4'd0 || !lead_q || idx_q == 4'd0) begin
            char_q  <= 8'h30 + {4'h0, cnt_q};
            valid_q <= 1'b1;
            lead_q  <= 1'b0;
            state_q <= EMIT;
          end else begin
            idx_q <= idx_q - 4'd1;
          end
        end
        EMIT: begin
          if (CHAR_READY) begin
            if (code_q != 32'd1) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (idx_q != 4'd0) begin
              valid_q <= 1'b0;
              idx_q   <= idx_q - 4'd1;
              cnt_q   <= '0;
              state_q <= DIGIT;
            end else if (NEWLINE_AFTER_INT != 0) begin
              char_q  <= 8'h0A;
              state_q <= NL;
            end else begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        NL: begin
          if (CHAR_READY) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= halt_q ? HALTED : IDLE;
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CHAR_OUT   = char_q;
  assign CHAR_VALID = valid_q;
  assign DONE_OUT   = done_q;
  assign BUSY_OUT   = busy_q;
  assign HALT_OUT   = halt_q;
  assign ERROR_OUT  = err_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: two instances (no newline / newline after
// integers) share all inputs; byte streams and pulses are checked per instance.
module tb_syscall_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        Syscall_IN;
  logic [31:0] V0_IN;
  logic [31:0] A0_IN;
  logic        CHAR_READY;
  logic [7:0]  c0, c1;
  logic        v0o, v1o, dn0, dn1, b0, b1, h0, h1, e0, e1;

  always #5 CLOCK = ~CLOCK;

  syscall_unit dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .Syscall_IN(Syscall_IN), .V0_IN(V0_IN),
    .A0_IN(A0_IN), .CHAR_READY(CHAR_READY), .CHAR_OUT(c0), .CHAR_VALID(v0o),
    .DONE_OUT(dn0), .BUSY_OUT(b0), .HALT_OUT(h0), .ERROR_OUT(e0)
  );

  syscall_unit #(.NEWLINE_AFTER_INT(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .Syscall_IN(Syscall_IN), .V0_IN(V0_IN),
    .A0_IN(A0_IN), .CHAR_READY(CHAR_READY), .CHAR_OUT(c1), .CHAR_VALID(v1o),
    .DONE_OUT(dn1), .BUSY_OUT(b1), .HALT_OUT(h1), .ERROR_OUT(e1)
  );

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          mode;
    logic [95:0] exp;
    int          nb;
    logic        xerr;
  } vec_t;

  vec_t        tv[10];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          d0, d1;
  int          rmode = 0;
  int          cyc = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic        st0 = 1'b0, st1 = 1'b0;
  logic [7:0]  pc0, pc1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Sampled mid-cycle: records transfers, DONE pulses and stall stability.
  task automatic monitor();
    if (RESET) begin
      st0 = 1'b0;
      st1 = 1'b0;
      return;
    end
    if (st0) chk("stall_hold0", {23'b0, v0o, c0}, {23'b0, 1'b1, pc0});
    if (st1) chk("stall_hold1", {23'b0, v1o, c1}, {23'b0, 1'b1, pc1});
    if (v0o && CHAR_READY) q0.push_back(c0);
    if (v1o && CHAR_READY) q1.push_back(c1);
    d0 += int'(dn0);
    d1 += int'(dn1);
    st0 = v0o && !CHAR_READY;
    st1 = v1o && !CHAR_READY;
    pc0 = c0;
    pc1 = c1;
  endtask

  task automatic tick();
    @(negedge CLOCK);
    monitor();
    @(posedge CLOCK);
    #1;
    cyc++;
    CHAR_READY = (rmode == 0) || (cyc % 3 == 0);
  endtask

  task automatic begin_obs();
    q0.delete();
    q1.delete();
    d0 = 0;
    d1 = 0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((d0 == 0 || d1 == 0) && k < budget) begin
      tick();
      k++;
    end
    chk("done_wait", {31'b0, (d0 != 0 && d1 != 0)}, 32'd1);
  endtask

  task automatic cmp_stream(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({nm, " len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s byte%0d", nm, i),
          (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF, {24'b0, exp[i]});
  endtask

  task automatic finish_req(input string nm, input logic [31:0] v0, input logic [95:0] exp,
                            input int nb, input logic xerr, input logic xhalt);
    logic [7:0] e[$];
    tick();
    tick();
    Syscall_IN = 1'b0;
    wait_done(800);
    repeat (3) tick();
    for (int i = 0; i < nb; i++) e.push_back(exp[8*(nb-1-i) +: 8]);
    cmp_stream({nm, "/nonl"}, q0, e);
    if (v0 == 32'd1) e.push_back(8'h0A);
    cmp_stream({nm, "/nl"}, q1, e);
    chk({nm, " done_cnt0"}, d0, 32'd1);
    chk({nm, " done_cnt1"}, d1, 32'd1);
    chk({nm, " err"}, {30'b0, e0, e1}, {30'b0, xerr, xerr});
    chk({nm, " halt"}, {30'b0, h0, h1}, {30'b0, xhalt, xhalt});
    chk({nm, " busy_after"}, {30'b0, b0, b1}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic quiet;

    tv[0] = '{32'd1,  32'd1234,       0, 96'("1234"),        4,  1'b0};
    tv[1] = '{32'd1,  32'h8000_0000,  0, 96'("-2147483648"), 11, 1'b0};
    tv[2] = '{32'd1,  32'd0,          1, 96'("0"),           1,  1'b0};
    tv[3] = '{32'd11, 32'h0000_0041,  1, 96'("A"),           1,  1'b0};
    tv[4] = '{32'd1,  32'hFFFF_FFF9,  1, 96'("-7"),          2,  1'b0};
    tv[5] = '{32'd1,  32'd1000000000, 0, 96'("1000000000"),  10, 1'b0};
    tv[6] = '{32'd1,  32'h7FFF_FFFF,  0, 96'("2147483647"),  10, 1'b0};
    tv[7] = '{32'd7,  32'd5,          0, 96'h0,              0,  1'b1};
    tv[8] = '{32'd11, 32'h1234_567A,  1, 96'("z"),           1,  1'b1};
    tv[9] = '{32'd1,  32'd105,        1, 96'("105"),         3,  1'b1};

    RESET = 1'b1; Syscall_IN = 1'b0; V0_IN = '0; A0_IN = '0; CHAR_READY = 1'b1;
    repeat (3) tick();
    chk("reset_state0", {18'b0, c0, v0o, dn0, b0, h0, e0}, 32'd0);
    chk("reset_state1", {18'b0, c1, v1o, dn1, b1, h1, e1}, 32'd0);
    RESET = 1'b0;
    tick();

    // print-char latency: capture edge, one DECODE cycle, then valid
    begin_obs();
    V0_IN = 32'd11; A0_IN = 32'h41; Syscall_IN = 1'b1;
    tick();
    chk("lat_decode", {28'b0, v0o, v1o, b0, b1}, 32'h3);
    tick();
    chk("lat_valid", {14'b0, v0o, v1o, c0, c1}, {14'b0, 1'b1, 1'b1, 8'h41, 8'h41});
    finish_req("lat", 32'd11, 96'("A"), 1, 1'b0, 1'b0);

    foreach (tv[i]) begin
      begin_obs();
      rmode = tv[i].mode;
      V0_IN = tv[i].v0; A0_IN = tv[i].a0; Syscall_IN = 1'b1;
      finish_req($sformatf("vec%0d", i), tv[i].v0, tv[i].exp, tv[i].nb, tv[i].xerr, 1'b0);
    end
    rmode = 0;

    // reset in the middle of printing 98765
    begin_obs();
    V0_IN = 32'd1; A0_IN = 32'd98765; Syscall_IN = 1'b1;
    k = 0;
    while (q0.size() < 2 && k < 300) begin
      tick();
      k++;
    end
    chk("rst_progress", {31'b0, q0.size() >= 2}, 32'd1);
    Syscall_IN = 1'b0;
    RESET = 1'b1;
    tick();
    chk("midrst_state0", {18'b0, c0, v0o, dn0, b0, h0, e0}, 32'd0);
    chk("midrst_state1", {18'b0, c1, v1o, dn1, b1, h1, e1}, 32'd0);
    RESET = 1'b0;
    begin_obs();
    repeat (6) tick();
    chk("midrst_no_done", d0 + d1, 32'd0);
    chk("midrst_no_bytes", q0.size() + q1.size(), 32'd0);
    begin_obs();
    V0_IN = 32'd1; A0_IN = 32'd42; Syscall_IN = 1'b1;
    finish_req("after_rst", 32'd1, 96'("42"), 2, 1'b0, 1'b0);

    // exit, then requests are ignored until reset
    begin_obs();
    V0_IN = 32'd10; A0_IN = 32'd0; Syscall_IN = 1'b1;
    finish_req("exit", 32'd10, 96'h0, 0, 1'b0, 1'b1);
    begin_obs();
    V0_IN = 32'd11; A0_IN = 32'h43; Syscall_IN = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      tick();
      if (v0o || v1o || b0 || b1) quiet = 1'b0;
    end
    chk("halted_quiet", {31'b0, quiet}, 32'd1);
    chk("halted_no_done", d0 + d1, 32'd0);
    chk("halted_no_bytes", q0.size() + q1.size(), 32'd0);
    chk("halted_sticky", {30'b0, h0, h1}, 32'h3);

    // request line already high across reset counts as a fresh edge
    A0_IN = 32'h42;
    RESET = 1'b1;
    tick();
    chk("halt_cleared", {30'b0, h0, h1}, 32'd0);
    RESET = 1'b0;
    begin_obs();
    finish_req("held_high", 32'd11, 96'("B"), 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 Parameter: NEWLINE_AFTER_INT, default 0, when 1 emit 0x0A after every printed integer.
REQ-002 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 Syscall_IN  input  1  level request from hazard unit; held high while syscall pending.
REQ-005 V0_IN  input  32  service code ($v0), valid whenever Syscall_IN high.
REQ-006 A0_IN  input  32  argument ($a0), valid whenever Syscall_IN high.
REQ-007 CHAR_READY  input  1  console sink accepts byte this cycle.
REQ-008 CHAR_OUT  output  8  ASCII byte to console.
REQ-009 CHAR_VALID  output  1  CHAR_OUT holds a byte for the sink.
REQ-010 DONE_OUT  output  1  one-cycle pulse: service complete.
REQ-011 BUSY_OUT  output  1  high from request capture until DONE_OUT cycle inclusive.
REQ-012 HALT_OUT  output  1  sticky: exit service executed.
REQ-013 ERROR_OUT  output  1  sticky: unsupported service code seen.

Function
REQ-014 Request start = rising edge of Syscall_IN (sampled 1, previous sample 0) while state IDLE; V0_IN, A0_IN latched at that edge.
REQ-015 Rising edges while not IDLE SHALL be ignored; no queuing.
REQ-016 States: IDLE, DECODE, SIGN, DIGIT, EMIT, NL, DONE, HALTED.
REQ-017 IDLE -> DECODE on start; DECODE dispatches on latched code next cycle.
REQ-018 Code 1 (print int): DECODE -> SIGN; if A0 negative emit '-' (0x2D), magnitude = two's-complement negation as 32-bit unsigned (0x80000000 -> 2147483648).
REQ-019 DIGIT: walk powers 10^9 down to 10^0; per power, subtract power from magnitude one subtraction per cycle while magnitude >= power, counting 0..9.
REQ-020 Digit emitted (0x30+count) via EMIT unless it is a leading zero; digit for 10^0 always emitted (value 0 prints "0").
REQ-021 After last digit: NL (emit 0x0A) if NEWLINE_AFTER_INT=1, else DONE.
REQ-022 Code 11 (print char): emit A0[7:0] once, then DONE.
REQ-023 Code 10 (exit): no output; set HALT_OUT, pulse DONE_OUT, enter HALTED.
REQ-024 Any other code: set ERROR_OUT, no output, DONE.
REQ-025 Handshake: byte transferred on cycle with CHAR_VALID & CHAR_READY; CHAR_OUT stable and CHAR_VALID held while CHAR_READY low; CHAR_VALID drops the cycle after transfer unless next byte immediately follows.
REQ-026 CHAR_VALID never asserted outside SIGN/EMIT/NL; no byte dropped or duplicated.
REQ-027 DONE: DONE_OUT high exactly one cycle, then IDLE; DONE_OUT no earlier than cycle after final transfer.
REQ-028 Minimum latency: start edge N -> first CHAR_VALID at N+2 for code 11.
REQ-029 HALTED: absorbing; all requests ignored, BUSY_OUT low, CHAR_VALID low, only RESET exits.
REQ-030 Syscall_IN dropping mid-service SHALL NOT abort; service completes on latched operands.

Reset
REQ-031 RESET high at clock edge: state IDLE, CHAR_VALID 0, CHAR_OUT 0x00, DONE_OUT 0, BUSY_OUT 0, HALT_OUT 0, ERROR_OUT 0, edge detector previous-sample 0.
REQ-032 RESET mid-service (including mid-handshake) overrides all; partial output discarded, no DONE_OUT.
REQ-033 After reset, Syscall_IN already high counts as a rising edge on first sampled cycle.

Verification
REQ-034 V0=1, A0=0x000004D2, READY=1 -> bytes "1","2","3","4" (0x31..0x34), one DONE_OUT pulse, ERROR/HALT stay 0.
REQ-035 V0=1, A0=0x80000000, NEWLINE_AFTER_INT=1 -> "-2147483648" then 0x0A, 12 transfers total.
REQ-036 V0=1, A0=0 with READY toggling 1-of-3 cycles -> single "0", CHAR_OUT stable during stall; V0=11, A0=0x41 -> single 0x41.
REQ-037 V0=10 -> HALT_OUT=1, DONE_OUT pulse, no bytes; later Syscall_IN rising edge -> no response until RESET.
REQ-038 V0=7 -> ERROR_OUT=1, DONE_OUT pulse, no bytes; second request V0=11 still serviced.
REQ-039 RESET asserted during digit emission of A0=98765 -> outputs at reset values next cycle, no DONE_OUT, new request serviced normally.
